// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port 32-bit word memory between an instruction
//             fetch requester (port 0) and a data load/store requester
//             (port 1). Round-robin arbitration, one transaction at a time,
//             IDLE -> ACCESS -> DONE. All memory-side signals are registered
//             and every access is checked for alignment and range before a
//             write strobe is allowed out.
//  Ports    : clk, rst_n               clock, async active-low reset
//             pX_req/we/addr/wdata     requester X transaction (held until ack)
//             pX_ack                   requester X completion, 1-cycle pulse
//             rsp_rdata, rsp_err       response of the acked transaction
//             mem_addr, MemWrite,
//             mem_write_data           registered memory interface
//             mem_read_data            combinational memory read of mem_addr
//             busy                     high while a transaction is in flight
//             gnt_cnt0, gnt_cnt1       saturating per-port grant counters
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned MEM_WORDS = 8192,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    output logic             p0_ack,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wdata,
    output logic             p1_ack,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [31:0]      mem_addr,
    output logic             MemWrite,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data,
    output logic             busy,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    // First illegal byte address; one extra bit so 4*MEM_WORDS never wraps.
    localparam logic [32:0] ADDR_LIMIT = {MEM_WORDS[30:0], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state_q;
    logic               last_grant_q;
    logic               win_q;
    logic               we_q;
    logic               illegal_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic               memwrite_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;
    logic               ack0_q;
    logic               ack1_q;
    logic [CNT_W-1:0]   cnt0_q;
    logic [CNT_W-1:0]   cnt1_q;

    // Arbitration and legality of the request presented this cycle.
    logic               grant_any_d;
    logic               win_d;
    logic               sel_we_d;
    logic [31:0]        sel_addr_d;
    logic [31:0]        sel_wdata_d;
    logic               sel_illegal_d;

    always_comb begin
        grant_any_d = p0_req | p1_req;
        // On a tie the port that did not win last time goes; otherwise
        // whichever single port is requesting.
        if (p0_req && p1_req) begin
            win_d = ~last_grant_q;
        end else begin
            win_d = ~p0_req;
        end
        sel_we_d      = win_d ? p1_we    : p0_we;
        sel_addr_d    = win_d ? p1_addr  : p0_addr;
        sel_wdata_d   = win_d ? p1_wdata : p0_wdata;
        sel_illegal_d = (sel_addr_d[1:0] != 2'b00) | ({1'b0, sel_addr_d} >= ADDR_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            illegal_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            memwrite_q   <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any_d) begin
                        win_q        <= win_d;
                        we_q         <= sel_we_d;
                        illegal_q    <= sel_illegal_d;
                        mem_addr_q   <= sel_addr_d;
                        mem_wdata_q  <= sel_wdata_d;
                        // An illegal write never strobes the memory.
                        memwrite_q   <= sel_we_d & ~sel_illegal_d;
                        last_grant_q <= win_d;
                        if (!win_d) begin
                            if (cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
                        end else begin
                            if (cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
                        end
                        state_q      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Memory write (if any) and async read both resolve at this edge.
                    if (illegal_q) begin
                        rsp_rdata_q <= ERR_DATA;
                    end else if (we_q) begin
                        rsp_rdata_q <= '0;
                    end else begin
                        rsp_rdata_q <= mem_read_data;
                    end
                    rsp_err_q  <= illegal_q;
                    memwrite_q <= 1'b0;
                    ack0_q     <= ~win_q;
                    ack1_q     <= win_q;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ack0_q     <= 1'b0;
                    ack1_q     <= 1'b0;
                    memwrite_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_ack         = ack0_q;
    assign p1_ack         = ack1_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign mem_addr       = mem_addr_q;
    assign MemWrite       = memwrite_q;
    assign mem_write_data = mem_wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign gnt_cnt0       = cnt0_q;
    assign gnt_cnt1       = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter. A behavioural
//             word memory sits on the memory port; a second instance with a
//             2-bit grant counter shares the same stimulus for saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack, rsp_err, MemWrite, busy;
    logic [31:0] rsp_rdata, mem_addr, mem_write_data, mem_read_data;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    // Outputs of the narrow-counter instance.
    logic        c2_p0_ack, c2_p1_ack, c2_rsp_err, c2_MemWrite, c2_busy;
    logic [31:0] c2_rsp_rdata, c2_mem_addr, c2_mem_write_data;
    logic [1:0]  c2_gnt_cnt0, c2_gnt_cnt1;

    logic [31:0] mem [0:8191];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .MemWrite(MemWrite), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .busy(busy),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    mem_port_arbiter #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(c2_p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(c2_p1_ack),
        .rsp_rdata(c2_rsp_rdata), .rsp_err(c2_rsp_err),
        .mem_addr(c2_mem_addr), .MemWrite(c2_MemWrite), .mem_write_data(c2_mem_write_data),
        .mem_read_data(mem_read_data), .busy(c2_busy),
        .gnt_cnt0(c2_gnt_cnt0), .gnt_cnt1(c2_gnt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: async read, posedge write, byte address >> 2.
    assign mem_read_data = (mem_addr < 32'h8000) ? mem[mem_addr[14:2]] : 32'h0;
    always @(posedge clk) begin
        if (MemWrite && (mem_addr < 32'h8000)) mem[mem_addr[14:2]] = mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // Entered just after a posedge. Waits (bounded) for an ack and returns
    // which port got it, posedges elapsed, MemWrite activity and the response.
    // Leaves just after the posedge that closes the DONE cycle.
    task automatic wait_ack(output int port, output int lat, output int mwc,
                            output logic [31:0] mwa, output logic [31:0] rd, output logic er);
        bit got;
        port = -1; lat = 0; mwc = 0; mwa = '0; rd = '0; er = 1'b0; got = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            if (MemWrite) begin mwc++; mwa = mem_addr; end
            if (p0_ack || p1_ack) begin
                got  = 1;
                port = (p0_ack && !p1_ack) ? 0 : ((p1_ack && !p0_ack) ? 1 : 2);
                rd   = rsp_rdata;
                er   = rsp_err;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int aport, output int lat, output int mwc,
                           output logic [31:0] mwa, output logic [31:0] rd, output logic er);
        issue(port, we, addr, wdata);
        wait_ack(aport, lat, mwc, mwa, rd, er);
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          aport, lat, mwc;
        logic [31:0] mwa, rd;
        logic        er;
        int          order_exp [6] = '{0, 1, 0, 1, 0, 1};
        logic [31:0] rd_exp    [6] = '{32'h1234_5678, 32'hCAFE_F00D, 32'h1234_5678,
                                       32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D};
        logic [31:0] sat_exp   [5] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};

        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem[0]  = 32'h5555_AAAA;
        mem[4]  = 32'h1234_5678;
        mem[32] = 32'h7777_8888;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_cnts", {gnt_cnt1, gnt_cnt0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: port 0 read of 0x10
        run_txn(0, 1'b0, 32'h10, 32'h0, aport, lat, mwc, mwa, rd, er);
        check("t1_port", 32'(aport), 32'd0);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_rdata", rd, 32'h1234_5678);
        check("t1_err", 32'(er), 32'd0);
        check("t1_memwrite_cnt", 32'(mwc), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: port 1 write 0x40 then read it back
        run_txn(1, 1'b1, 32'h40, 32'hCAFE_F00D, aport, lat, mwc, mwa, rd, er);
        check("t2w_port", 32'(aport), 32'd1);
        check("t2w_memwrite_cnt", 32'(mwc), 32'd1);
        check("t2w_mem_addr", mwa, 32'h40);
        check("t2w_rdata_zero", rd, 32'h0);
        check("t2w_mem16", mem[16], 32'hCAFE_F00D);
        run_txn(1, 1'b0, 32'h40, 32'h0, aport, lat, mwc, mwa, rd, er);
        check("t2r_rdata", rd, 32'hCAFE_F00D);
        check("t2r_memwrite_cnt", 32'(mwc), 32'd0);

        // 3: both ports request continuously
        do_reset();
        issue(0, 1'b0, 32'h10, 32'h0);
        issue(1, 1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 6; k++) begin
            wait_ack(aport, lat, mwc, mwa, rd, er);
            check($sformatf("t3_order%0d", k), 32'(aport), 32'(order_exp[k]));
            check($sformatf("t3_rdata%0d", k), rd, rd_exp[k]);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check("t3_cnt0", 32'(gnt_cnt0), 32'd3);
        check("t3_cnt1", 32'(gnt_cnt1), 32'd3);

        // 4: illegal accesses and the last legal word
        run_txn(1, 1'b1, 32'h42, 32'h1111_1111, aport, lat, mwc, mwa, rd, er);
        check("t4a_memwrite_cnt", 32'(mwc), 32'd0);
        check("t4a_err", 32'(er), 32'd1);
        check("t4a_rdata", rd, 32'hDEAD_BEEF);
        check("t4a_mem16", mem[16], 32'hCAFE_F00D);
        run_txn(1, 1'b1, 32'h8000, 32'h2222_2222, aport, lat, mwc, mwa, rd, er);
        check("t4b_memwrite_cnt", 32'(mwc), 32'd0);
        check("t4b_err", 32'(er), 32'd1);
        check("t4b_rdata", rd, 32'hDEAD_BEEF);
        check("t4b_mem0", mem[0], 32'h5555_AAAA);
        run_txn(0, 1'b0, 32'h11, 32'h0, aport, lat, mwc, mwa, rd, er);
        check("t4c_read_err", 32'(er), 32'd1);
        check("t4c_read_rdata", rd, 32'hDEAD_BEEF);
        run_txn(1, 1'b1, 32'h7FFC, 32'hA5A5_0001, aport, lat, mwc, mwa, rd, er);
        check("t4d_memwrite_cnt", 32'(mwc), 32'd1);
        check("t4d_err", 32'(er), 32'd0);
        check("t4d_mem8191", mem[8191], 32'hA5A5_0001);

        // 5: asynchronous reset during ACCESS of a write
        issue(0, 1'b1, 32'h80, 32'h1111_2222);
        @(posedge clk); #2;
        check("t5_memwrite_pre", 32'(MemWrite), 32'd1);
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_memwrite_rst", 32'(MemWrite), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_acks_rst", {30'd0, p1_ack, p0_ack}, 32'd0);
        check("t5_cnts_rst", {gnt_cnt1, gnt_cnt0}, 32'd0);
        p0_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_mem32", mem[32], 32'h7777_8888);
        rst_n = 1'b1;

        // 6: saturating 2-bit counter
        for (int k = 0; k < 5; k++) begin
            run_txn(0, 1'b0, 32'h10, 32'h0, aport, lat, mwc, mwa, rd, er);
            check($sformatf("t6_port%0d", k), 32'(aport), 32'd0);
            check($sformatf("t6_cnt2_%0d", k), 32'(c2_gnt_cnt0), sat_exp[k]);
        end
        check("t6_cnt16", 32'(gnt_cnt0), 32'd5);
        check("t6_cnt16_p1", 32'(gnt_cnt1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
